// File: rtl/bp_fe_chooser_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bp_fe_chooser_pkg
// Purpose  : Shared types and constants for the front-end tournament chooser.
//            Holds the choice-counter type and constants at the default
//            width, the lookup/training request structs and the helper that
//            turns a training outcome into a counter step direction.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package bp_fe_chooser_pkg;

  localparam int unsigned CTR_WIDTH_DEFAULT = 2;

  typedef logic [CTR_WIDTH_DEFAULT-1:0] chooser_ctr_t;

  // Counter MSB set = prefer global; reset lands on the weakest global value.
  localparam chooser_ctr_t CTR_WEAK_GLOBAL = chooser_ctr_t'(1 << (CTR_WIDTH_DEFAULT - 1));
  localparam chooser_ctr_t CTR_MAX         = '1;

  typedef enum logic [1:0] {
    CTR_HOLD = 2'd0,
    CTR_INC  = 2'd1,
    CTR_DEC  = 2'd2
  } ctr_dir_e;

  typedef struct packed {
    logic v;
    logic global_pred;
    logic local_pred;
  } pred_req_t;

  typedef struct packed {
    logic v;
    logic global_ok;
    logic local_ok;
  } upd_req_t;

  // Only a decisive outcome (exactly one predictor right) moves the counter.
  function automatic ctr_dir_e upd_dir_f(upd_req_t req);
    ctr_dir_e dir;
    dir = CTR_HOLD;
    if (req.v) begin
      if (req.global_ok && !req.local_ok) begin
        dir = CTR_INC;
      end else if (!req.global_ok && req.local_ok) begin
        dir = CTR_DEC;
      end
    end
    return dir;
  endfunction

endpackage : bp_fe_chooser_pkg
`default_nettype wire

// File: rtl/bp_fe_sat_ctr.sv
`default_nettype none
// ============================================================================
// Module   : bp_fe_sat_ctr
// Purpose  : One saturating up/down choice counter with an async reset value.
//            Also exposes the value it will take at the next edge so the
//            parent can forward a same-cycle update to a lookup.
// Ports    : clk_i      - clock
//            reset_i    - async active-high reset, loads RESET_VAL_P
//            dir_i      - hold / increment / decrement this cycle
//            ctr_o      - current counter value
//            ctr_next_o - value after this cycle's step (saturated)
// Revision : 1.0 - initial release
// ============================================================================
module bp_fe_sat_ctr
  import bp_fe_chooser_pkg::*;
#(
  parameter int                 WIDTH_P     = CTR_WIDTH_DEFAULT,
  parameter logic [WIDTH_P-1:0] RESET_VAL_P = WIDTH_P'(1) << (WIDTH_P - 1)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  ctr_dir_e           dir_i,
  output logic [WIDTH_P-1:0] ctr_o,
  output logic [WIDTH_P-1:0] ctr_next_o
);

  localparam logic [WIDTH_P-1:0] c_ctr_max = '1;

  logic [WIDTH_P-1:0] r_ctr;

  always_comb begin
    ctr_next_o = r_ctr;
    case (dir_i)
      CTR_INC: if (r_ctr != c_ctr_max) ctr_next_o = r_ctr + WIDTH_P'(1);
      CTR_DEC: if (r_ctr != '0)        ctr_next_o = r_ctr - WIDTH_P'(1);
      default: ctr_next_o = r_ctr;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_ctr <= RESET_VAL_P;
    end else begin
      r_ctr <= ctr_next_o;
    end
  end

  assign ctr_o = r_ctr;

endmodule : bp_fe_sat_ctr
`default_nettype wire

// File: rtl/bp_fe_tournament_chooser.sv
`default_nettype none
// ============================================================================
// Module   : bp_fe_tournament_chooser
// Purpose  : Tournament chooser between global and local branch predictors.
//            A table of saturating choice counters is read at lookup time;
//            the choice is delivered one cycle later. Counters are trained on
//            branch resolution, and lookups where the predictors disagreed
//            are counted in a saturating perf counter.
// Ports    : clk_i, reset_i          - clock, async active-high reset
//            pred_v_i / pred_idx_i   - lookup request and counter index
//            global_pred_i/local_pred_i - the two candidate predictions
//            flush_i                 - kills the lookup in flight
//            pred_v_o                - prediction valid (1 cycle latency)
//            pred_taken_o            - final taken prediction
//            pred_sel_global_o       - global chosen (or predictors agreed)
//            upd_v_i / upd_idx_i     - training request and counter index
//            upd_global_ok_i/upd_local_ok_i - which predictor was right
//            disagree_cnt_o          - saturating disagreement count
// Revision : 1.0 - initial release
// ============================================================================
module bp_fe_tournament_chooser
  import bp_fe_chooser_pkg::*;
#(
  parameter  int ENTRIES_P    = 256,
  parameter  int CTR_WIDTH_P  = 2,
  parameter  int STAT_WIDTH_P = 16,
  localparam int IDX_WIDTH_LP = $clog2(ENTRIES_P)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,

  input  logic                    pred_v_i,
  input  logic [IDX_WIDTH_LP-1:0] pred_idx_i,
  input  logic                    global_pred_i,
  input  logic                    local_pred_i,
  input  logic                    flush_i,
  output logic                    pred_v_o,
  output logic                    pred_taken_o,
  output logic                    pred_sel_global_o,

  input  logic                    upd_v_i,
  input  logic [IDX_WIDTH_LP-1:0] upd_idx_i,
  input  logic                    upd_global_ok_i,
  input  logic                    upd_local_ok_i,

  output logic [STAT_WIDTH_P-1:0] disagree_cnt_o
);

  localparam logic [CTR_WIDTH_P-1:0]  c_ctr_reset = CTR_WIDTH_P'(1) << (CTR_WIDTH_P - 1);
  localparam logic [STAT_WIDTH_P-1:0] c_stat_max  = '1;

  // --------------------------------------------------------------------------
  // Counter table
  // --------------------------------------------------------------------------
  upd_req_t                w_upd_req;
  ctr_dir_e                w_upd_dir;
  ctr_dir_e                w_entry_dir [ENTRIES_P];
  logic [CTR_WIDTH_P-1:0]  w_ctr       [ENTRIES_P];
  logic [CTR_WIDTH_P-1:0]  w_ctr_next  [ENTRIES_P];

  assign w_upd_req = '{v: upd_v_i, global_ok: upd_global_ok_i, local_ok: upd_local_ok_i};
  assign w_upd_dir = upd_dir_f(w_upd_req);

  for (genvar i = 0; i < ENTRIES_P; i++) begin : g_ctr
    assign w_entry_dir[i] = (upd_idx_i == IDX_WIDTH_LP'(i)) ? w_upd_dir : CTR_HOLD;

    bp_fe_sat_ctr #(
      .WIDTH_P     (CTR_WIDTH_P),
      .RESET_VAL_P (c_ctr_reset)
    ) u_ctr (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .dir_i      (w_entry_dir[i]),
      .ctr_o      (w_ctr[i]),
      .ctr_next_o (w_ctr_next[i])
    );
  end

  // --------------------------------------------------------------------------
  // Lookup read with write-through bypass: a same-index update in this cycle
  // is visible to the lookup, so take the counter's next value instead.
  // --------------------------------------------------------------------------
  logic                   w_bypass;
  logic [CTR_WIDTH_P-1:0] w_rd_ctr;
  logic                   w_rd_msb;
  pred_req_t              w_pred_req;

  assign w_bypass   = (w_upd_dir != CTR_HOLD) && (upd_idx_i == pred_idx_i);
  assign w_rd_ctr   = w_bypass ? w_ctr_next[pred_idx_i] : w_ctr[pred_idx_i];
  assign w_rd_msb   = w_rd_ctr[CTR_WIDTH_P-1];
  assign w_pred_req = '{v:           pred_v_i & ~flush_i,
                        global_pred: global_pred_i,
                        local_pred:  local_pred_i};

  // --------------------------------------------------------------------------
  // Lookup register stage
  // --------------------------------------------------------------------------
  pred_req_t r_pred_req;
  logic      r_msb;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_pred_req <= '0;
      r_msb      <= 1'b0;
    end else begin
      r_pred_req <= w_pred_req;
      r_msb      <= w_rd_msb;
    end
  end

  // --------------------------------------------------------------------------
  // Output select. A flush in the output cycle still kills the result, so the
  // valid and the perf-counter increment are both gated combinationally.
  // --------------------------------------------------------------------------
  logic w_fire;
  logic w_agree;
  logic w_sel_global;
  logic w_taken;
  logic r_taken_hold;
  logic r_sel_hold;

  assign w_fire       = r_pred_req.v & ~flush_i;
  assign w_agree      = (r_pred_req.global_pred == r_pred_req.local_pred);
  assign w_sel_global = w_agree | r_msb;
  assign w_taken      = w_sel_global ? r_pred_req.global_pred : r_pred_req.local_pred;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_taken_hold <= 1'b0;
      r_sel_hold   <= 1'b0;
    end else if (w_fire) begin
      r_taken_hold <= w_taken;
      r_sel_hold   <= w_sel_global;
    end
  end

  assign pred_v_o          = w_fire;
  assign pred_taken_o      = w_fire ? w_taken      : r_taken_hold;
  assign pred_sel_global_o = w_fire ? w_sel_global : r_sel_hold;

  // --------------------------------------------------------------------------
  // Disagreement perf counter; the visible value already includes the lookup
  // completing in this cycle.
  // --------------------------------------------------------------------------
  logic [STAT_WIDTH_P-1:0] r_disagree_cnt;
  logic [STAT_WIDTH_P-1:0] w_disagree_cnt_next;

  assign w_disagree_cnt_next = (w_fire && !w_agree && (r_disagree_cnt != c_stat_max))
                             ? r_disagree_cnt + STAT_WIDTH_P'(1)
                             : r_disagree_cnt;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_disagree_cnt <= '0;
    end else begin
      r_disagree_cnt <= w_disagree_cnt_next;
    end
  end

  assign disagree_cnt_o = w_disagree_cnt_next;

endmodule : bp_fe_tournament_chooser
`default_nettype wire
